// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding, defaults and sizing helper for serial_subtractor
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // One extra bit beyond what indexes WIDTH bits, so the count never wraps mid-operation.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational one-bit full subtractor cell (d = a - b - bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit is the parity of the three inputs.
  assign d    = a ^ b ^ bin;
  // Borrow out when b exceeds a, or when they match and a borrow comes in.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor; SERIAL_SUBTRACTOR_SIGNED_OVF_EN adds signed overflow output ovf
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             cell_d;
  logic             cell_bout;

  // The only arithmetic in the block: one cell fed by the operand LSBs and the stored borrow.
  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Control FSM plus the operand/result shift registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      cnt        <= '0;
      borrow     <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow   <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end

        RUN: begin
          // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at diff[0].
          diff   <= {cell_d, diff[WIDTH-1:1]};
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          borrow <= cell_bout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            borrow_out <= cell_bout;
            out_valid  <= 1'b1;
            state      <= DONE;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
            // At the last step the cell inputs are the operand sign bits and cell_d is the result sign.
            ovf <= (a_sr[0] != b_sr[0]) && (cell_d != a_sr[0]);
`endif
          end
        end

        DONE: begin
          // Re-accept waits for the IDLE cycle so in_ready never rises in the handshake cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH=8
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
  logic         ovf;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W:0] full;
    exp_t e;
    full = {1'b0, av} - {1'b0, bv};
    e.d  = full[W-1:0];
    e.bo = full[W];
    e.ov = (av[W-1] != bv[W-1]) && (full[W-1] != av[W-1]);
    exp_q.push_back(e);
  endtask

  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av;
    b = bv;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output logic ready_seen);
    lat = 0;
    ready_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (diff !== 8'h00) begin miscompares++; $display("FAIL reset_diff got %h want 00", diff); end
    vectors++;
    if (borrow_out !== 1'b0) begin miscompares++; $display("FAIL reset_borrow got %b want 0", borrow_out); end
  endtask

  task automatic test_basic();
    int lat;
    logic rs;
    exp_t e;
    push_exp(8'h05, 8'h03);
    out_ready = 1'b1;
    accept(8'h05, 8'h03);
    wait_valid(lat, rs);
    e = exp_q.pop_front();
    vectors++;
    if (lat !== W) begin miscompares++; $display("FAIL basic_latency got %0d want %0d", lat, W); end
    vectors++;
    if (rs !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_run got %b want 0", rs); end
    vectors++;
    if (diff !== e.d || borrow_out !== e.bo) begin
      miscompares++; $display("FAIL basic_result got %h/%b want %h/%b", diff, borrow_out, e.d, e.bo);
    end
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL basic_idle got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_underflow();
    int lat;
    logic rs;
    exp_t e;
    push_exp(8'h00, 8'h01);
    accept(8'h00, 8'h01);
    wait_valid(lat, rs);
    e = exp_q.pop_front();
    vectors++;
    if (lat !== W || diff !== e.d || borrow_out !== e.bo) begin
      miscompares++; $display("FAIL underflow got lat=%0d %h/%b want lat=%0d %h/%b", lat, diff, borrow_out, W, e.d, e.bo);
    end
    consume();
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    push_exp(8'h80, 8'h01);
    accept(8'h80, 8'h01);
    wait_valid(lat, rs);
    e = exp_q.pop_front();
    vectors++;
    if (diff !== e.d || borrow_out !== e.bo || ovf !== e.ov) begin
      miscompares++; $display("FAIL signed_ovf got %h/%b/%b want %h/%b/%b", diff, borrow_out, ovf, e.d, e.bo, e.ov);
    end
    consume();
`endif
  endtask

  task automatic test_backpressure();
    int lat;
    logic rs;
    exp_t e;
    push_exp(8'hA5, 8'hA5);
    accept(8'hA5, 8'hA5);
    wait_valid(lat, rs);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || diff !== e.d || borrow_out !== e.bo) begin
        miscompares++; $display("FAIL hold_%0d got v=%b %h/%b want v=1 %h/%b", i, out_valid, diff, borrow_out, e.d, e.bo);
      end
      @(negedge clk);
    end
    consume();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL hold_release got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic rs;
    logic spurious;
    exp_t e;
    accept(8'h3C, 8'h0F);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      miscompares++; $display("FAIL midrun_reset got r=%b v=%b d=%h bo=%b want 1/0/00/0", in_ready, out_valid, diff, borrow_out);
    end
    spurious = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) spurious = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (spurious !== 1'b0) begin miscompares++; $display("FAIL midrun_spurious got %b want 0", spurious); end
    push_exp(8'h3C, 8'h0F);
    accept(8'h3C, 8'h0F);
    wait_valid(lat, rs);
    e = exp_q.pop_front();
    vectors++;
    if (lat !== W || diff !== e.d || borrow_out !== e.bo) begin
      miscompares++; $display("FAIL midrun_fresh got lat=%0d %h/%b want lat=%0d %h/%b", lat, diff, borrow_out, W, e.d, e.bo);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    int got;
    logic second;
    exp_t e;
    push_exp(8'h10, 8'h01);
    push_exp(8'h01, 8'h10);
    out_ready = 1'b1;
    a = 8'h10;
    b = 8'h01;
    in_valid = 1'b1;
    t1 = cyc;
    t2 = -1;
    got = 0;
    second = 1'b0;
    @(negedge clk);
    a = 8'h01;
    b = 8'h10;
    for (int i = 0; i < 60 && got < 2; i++) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        vectors++;
        if (diff !== e.d || borrow_out !== e.bo) begin
          miscompares++; $display("FAIL b2b_result_%0d got %h/%b want %h/%b", got, diff, borrow_out, e.d, e.bo);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        t2 = cyc;
        second = 1'b1;
      end
      @(negedge clk);
      if (second) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (got !== 2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", got); end
    vectors++;
    if (t2 - t1 !== W + 2) begin miscompares++; $display("FAIL b2b_spacing got %0d want %0d", t2 - t1, W + 2); end
    exp_q.delete();
  endtask

  task automatic test_ignore_during_run();
    int lat;
    logic rs;
    logic idle_ok;
    exp_t e;
    push_exp(8'h9A, 8'h27);
    accept(8'h9A, 8'h27);
    repeat (2) @(negedge clk);
    a = 8'hFF;
    b = 8'h01;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    wait_valid(lat, rs);
    e = exp_q.pop_front();
    vectors++;
    if (lat !== W - 4 || rs !== 1'b0) begin
      miscompares++; $display("FAIL ignore_timing got lat=%0d ready=%b want %0d/0", lat, rs, W - 4);
    end
    vectors++;
    if (diff !== e.d || borrow_out !== e.bo) begin
      miscompares++; $display("FAIL ignore_result got %h/%b want %h/%b", diff, borrow_out, e.d, e.bo);
    end
    consume();
    idle_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid || !in_ready) idle_ok = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (idle_ok !== 1'b1) begin miscompares++; $display("FAIL ignore_no_second_op got %b want 1", idle_ok); end
  endtask

  task automatic test_random();
    int lat;
    logic rs;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    exp_t e;
    for (int n = 0; n < 8; n++) begin
      av = W'($urandom);
      bv = W'($urandom);
      push_exp(av, bv);
      accept(av, bv);
      wait_valid(lat, rs);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (lat !== W || diff !== e.d || borrow_out !== e.bo) begin
        miscompares++; $display("FAIL random_%0d %h-%h got lat=%0d %h/%b want lat=%0d %h/%b", n, av, bv, lat, diff, borrow_out, W, e.d, e.bo);
      end
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
      vectors++;
      if (ovf !== e.ov) begin miscompares++; $display("FAIL random_ovf_%0d got %b want %b", n, ovf, e.ov); end
`endif
      consume();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_underflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_ignore_during_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
